// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state, owner and width encodings for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic {OWNER_IF, OWNER_DM} owner_t;

    localparam logic [1:0] WIDTH_HALF = 2'b01;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and memory_interface signals of the arbiter; slave = arbiter side
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_done;
    logic [15:0]       if_rdata;
    logic              dm_load_req;
    logic              dm_store_req;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [1:0]        dm_width;
    logic              dm_signed;
    logic              dm_gnt;
    logic              dm_done;
    logic [DATA_W-1:0] dm_rdata;
    logic              mi_load;
    logic              mi_store;
    logic [ADDR_W-1:0] mi_addr;
    logic [DATA_W-1:0] mi_data;
    logic [1:0]        mi_word_type;
    logic              mi_is_signed;
    logic              mi_output_valid;
    logic              mi_write_ready;
    logic              mi_busy;
    logic [DATA_W-1:0] mi_rdata;
    logic              timeout_err;

    modport slave (
        input  if_req, if_addr, dm_load_req, dm_store_req, dm_addr, dm_wdata, dm_width, dm_signed,
        input  mi_output_valid, mi_write_ready, mi_busy, mi_rdata,
        output if_gnt, if_done, if_rdata, dm_gnt, dm_done, dm_rdata,
        output mi_load, mi_store, mi_addr, mi_data, mi_word_type, mi_is_signed, timeout_err
    );

    modport master (
        output if_req, if_addr, dm_load_req, dm_store_req, dm_addr, dm_wdata, dm_width, dm_signed,
        output mi_output_valid, mi_write_ready, mi_busy, mi_rdata,
        input  if_gnt, if_done, if_rdata, dm_gnt, dm_done, dm_rdata,
        input  mi_load, mi_store, mi_addr, mi_data, mi_word_type, mi_is_signed, timeout_err
    );

endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// mem_arb_watchdog: counts WAIT cycles and flags expiry at TIMEOUT_CYCLES-1
import mem_arb_pkg::*;

module mem_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = $clog2(TIMEOUT_CYCLES);

    logic [W-1:0] cnt;

    assign expire = enable && cnt == W'(TIMEOUT_CYCLES - 1);

    // count while enabled, restart on clear, park at the expiry value
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && !expire)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: registered fetch/data arbiter for memory_interface; MEM_ARB_ROUND_ROBIN_EN selects round-robin conflicts
import mem_arb_pkg::*;

module mem_port_arbiter #(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic                clock,
    input logic                reset,
    mem_port_arbiter_if.slave  bus
);

    state_t state;
    owner_t owner;
    logic   is_store;
    logic   dm_pend;
    logic   pick_if;
    logic   take;
    logic   complete;
    logic   expire;

    assign dm_pend  = bus.dm_load_req | bus.dm_store_req;
    assign take     = state == IDLE && !bus.mi_busy && (bus.if_req || dm_pend);
    assign complete = state == WAIT && (is_store ? bus.mi_write_ready : bus.mi_output_valid);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_t last_owner;

    assign pick_if = bus.if_req && (!dm_pend || last_owner == OWNER_DM);

    // remember who was granted so the next conflict goes to the other requester
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            last_owner <= OWNER_DM;
        else if (take)
            last_owner <= pick_if ? OWNER_IF : OWNER_DM;
    end
`else
    assign pick_if = bus.if_req;
`endif

    mem_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (state == ISSUE),
        .enable (state == WAIT),
        .expire (expire)
    );

    // access sequencer: grant, issue one strobe, wait for completion or timeout, report done
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            owner            <= OWNER_IF;
            is_store         <= 1'b0;
            bus.if_gnt       <= 1'b0;
            bus.dm_gnt       <= 1'b0;
            bus.if_done      <= 1'b0;
            bus.dm_done      <= 1'b0;
            bus.if_rdata     <= '0;
            bus.dm_rdata     <= '0;
            bus.mi_load      <= 1'b0;
            bus.mi_store     <= 1'b0;
            bus.mi_addr      <= '0;
            bus.mi_data      <= '0;
            bus.mi_word_type <= '0;
            bus.mi_is_signed <= 1'b0;
            bus.timeout_err  <= 1'b0;
        end else begin
            bus.if_gnt      <= 1'b0;
            bus.dm_gnt      <= 1'b0;
            bus.if_done     <= 1'b0;
            bus.dm_done     <= 1'b0;
            bus.mi_load     <= 1'b0;
            bus.mi_store    <= 1'b0;
            bus.timeout_err <= 1'b0;
            case (state)
                IDLE: if (take) begin
                    state            <= ISSUE;
                    owner            <= pick_if ? OWNER_IF : OWNER_DM;
                    is_store         <= !pick_if && bus.dm_store_req;
                    bus.if_gnt       <= pick_if;
                    bus.dm_gnt       <= !pick_if;
                    bus.mi_load      <= pick_if || !bus.dm_store_req;
                    bus.mi_store     <= !pick_if && bus.dm_store_req;
                    bus.mi_addr      <= pick_if ? bus.if_addr : bus.dm_addr;
                    bus.mi_data      <= pick_if ? DATA_W'(0) : bus.dm_wdata;
                    bus.mi_word_type <= pick_if ? WIDTH_HALF : bus.dm_width;
                    bus.mi_is_signed <= !pick_if && bus.dm_signed;
                end
                ISSUE: state <= WAIT;
                WAIT: if (complete || expire) begin
                    state           <= DONE;
                    bus.if_done     <= owner == OWNER_IF;
                    bus.dm_done     <= owner == OWNER_DM;
                    bus.timeout_err <= !complete;
                    bus.if_rdata    <= complete && owner == OWNER_IF ? bus.mi_rdata[15:0] : 16'h0;
                    bus.dm_rdata    <= complete && owner == OWNER_DM ? bus.mi_rdata : DATA_W'(0);
                end
                DONE: begin
                    state            <= IDLE;
                    bus.if_rdata     <= '0;
                    bus.dm_rdata     <= '0;
                    bus.mi_addr      <= ADDR_W'(0);
                    bus.mi_data      <= '0;
                    bus.mi_word_type <= '0;
                    bus.mi_is_signed <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Arbitrates the single `memory_interface` port between two requesters: instruction fetch (halfword loads) and decoder data accesses (loads and stores).
- Replaces the combinational fetch-wins mux in `cpu` with a registered controller.
- Sequences each access: grant → issue → wait for completion → done.
- Guards every access with a timeout watchdog.

## Interface

Parameters:
- `ADDR_W`, 12, memory word address width
- `DATA_W`, 32, data-side write/read width
- `TIMEOUT_CYCLES`, 64, maximum cycles in WAIT before abort (must be ≥ 2)

Ports:
- `clock` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `if_req` in 1: fetch load request (level)
- `if_addr` in ADDR_W: fetch address
- `if_gnt` out 1: fetch request accepted (1-cycle pulse)
- `if_done` out 1: fetch complete (1-cycle pulse)
- `if_rdata` out 16: fetched halfword, valid with `if_done`
- `dm_load_req` in 1: data load request (level)
- `dm_store_req` in 1: data store request (level)
- `dm_addr` in ADDR_W: data address
- `dm_wdata` in DATA_W: store data
- `dm_width` in 2: load/store width code
- `dm_signed` in 1: sign-extend load
- `dm_gnt` out 1: data request accepted (1-cycle pulse)
- `dm_done` out 1: data access complete (1-cycle pulse)
- `dm_rdata` out DATA_W: load result, valid with `dm_done`
- `mi_load`, `mi_store` out 1: to memory_interface `load`/`store`
- `mi_addr` out ADDR_W: to memory_interface `address`
- `mi_data` out DATA_W: to memory_interface `data_in`
- `mi_word_type` out 2, `mi_is_signed` out 1: to memory_interface
- `mi_output_valid`, `mi_write_ready`, `mi_busy` in 1: from memory_interface
- `mi_rdata` in DATA_W: memory_interface `data_out`
- `timeout_err` out 1: watchdog abort (1-cycle pulse)

## Operation

- FSM states:
  - IDLE: wait for a request.
  - ISSUE: drive one cycle of `mi_load`/`mi_store`.
  - WAIT: wait for completion or timeout.
  - DONE: signal completion, then return to IDLE.
- IDLE:
  - Accepts a request only when `mi_busy` = 0.
  - Selects the owner and latches the owner's address, wdata, width and signed into registers.
  - Pulses the owner's `gnt` and goes to ISSUE.
- Fetch access: `mi_word_type` = 2'b01, `mi_is_signed` = 0, `mi_data` = 0.
- Data access:
  - `dm_store_req` and `dm_load_req` both high: store wins. This combination is illegal; the bench flags it.
- ISSUE: `mi_load` or `mi_store` is high for exactly this cycle. Next state is WAIT.
- WAIT:
  - A load completes on `mi_output_valid`; a store completes on `mi_write_ready`.
  - On completion, capture `mi_rdata` and go to DONE.
  - Completion inputs are ignored in every other state.
- DONE:
  - Pulse the owner's `done`. `if_rdata` = `mi_rdata[15:0]`; `dm_rdata` = full `mi_rdata`.
  - Requests are ignored in this cycle; the requester drops its request here.
  - Next state is IDLE.
- Timeout: a watchdog counter clears on entry to WAIT. If it reaches `TIMEOUT_CYCLES`-1 without completion:
  - pulse `timeout_err`;
  - deliver `done` with rdata = 0;
  - go to DONE.
- `mi_addr`, `mi_data`, `mi_word_type` and `mi_is_signed` hold the latched values from ISSUE through DONE. They are 0 in IDLE.
- Reset, including mid-access:
  - FSM returns to IDLE and the watchdog clears.
  - All outputs are 0.
  - Last-owner register resets to DATA.

## Timing

- Request seen in IDLE at cycle 0: `gnt` and `mi_load`/`mi_store` high in cycle 1 (ISSUE); WAIT from cycle 2.
- Completion input in cycle N: `done` and rdata in cycle N+1; IDLE in cycle N+2.
- The earliest next grant is at cycle N+3.
- Minimum access occupancy is 4 cycles (completion in cycle 2).
- All outputs are registered; there is no combinational input-to-output path.

## Configuration

- `MEM_ARB_ROUND_ROBIN_EN`:
  - Defined: when both requesters are pending in IDLE, grant goes to the requester not granted last. The first conflict after reset goes to fetch.
  - Undefined: fixed priority, fetch always wins a conflict. The last-owner register is omitted.

## Structure

- `mem_arb_pkg`:
  - state enum (IDLE, ISSUE, WAIT, DONE);
  - owner encoding (OWNER_IF, OWNER_DM);
  - `WIDTH_HALF` = 2'b01.
- Sub-module `mem_arb_watchdog`:
  - inputs: clear and enable;
  - output: expire pulse;
  - width $clog2(TIMEOUT_CYCLES).

## Test plan

- Fetch only: `if_req`=1, `if_addr`=12'h010, `mi_output_valid` in cycle 4, `mi_rdata`=32'h0000_B500. Expect `if_gnt`@1, `mi_load`@1 with `mi_word_type`=01, `if_done`@5 with `if_rdata`=16'hB500.
- Store: `dm_store_req`=1, `dm_addr`=12'h100, `dm_wdata`=32'hDEAD_BEEF, `dm_width`=2'b10. Expect `mi_store`@1 with those values held; `dm_done` one cycle after `mi_write_ready`.
- Conflict: `if_req` and `dm_load_req` high together, held for two accesses.
  - Fixed priority: fetch served in both accesses.
  - Round-robin: fetch, then data.
- Busy gating: `mi_busy`=1 for cycles 0–5 with `if_req`=1. Expect no grant until the cycle after `mi_busy` falls.
- Timeout: `TIMEOUT_CYCLES`=8, data load with no completion. Expect `timeout_err` and `dm_done` together, `dm_rdata`=0, IDLE the next cycle.
- Reset asserted during WAIT: all outputs 0 immediately; next request is granted normally after release.
